// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   - FSM state encoding (2-bit constants)
//   - Source indices: SRC_REG (register-read byte), SRC_ALU (16-bit ALU word)
//   - Bytes per frame for each source
package uart_sched_pkg;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_IDLE    = 2'd0;
  localparam sched_state_t ST_SEND    = 2'd1;
  localparam sched_state_t ST_WAIT_HI = 2'd2;
  localparam sched_state_t ST_WAIT_LO = 2'd3;

  localparam int SRC_REG = 0;
  localparam int SRC_ALU = 1;

  localparam int BYTES_REG = 1;
  localparam int BYTES_ALU = 2;

endpackage

// File: rtl/uart_sched_pending.sv
// One request slot of the transmit scheduler: pending bit plus data register.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   valid_i, data_i    one-cycle request strobe and its data
//   grant_i            scheduler takes the held data this cycle
//   pending_o          slot currently holds data
//   pending_next_o     value pending_o takes after this edge
//   data_o             held data
//   overflow_o         request dropped this cycle (slot busy, not granted)
module uart_sched_pending #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             grant_i,
  output logic             pending_o,
  output logic             pending_next_o,
  output logic [WIDTH-1:0] data_o,
  output logic             overflow_o
);

  logic             pending_q, pending_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    pending_d  = pending_q;
    data_d     = data_q;
    overflow_o = 1'b0;
    if (grant_i) pending_d = 1'b0;
    if (valid_i) begin
      // A grant in the same cycle frees the slot, so the new request is kept.
      if (!pending_q || grant_i) begin
        pending_d = 1'b1;
        data_d    = data_i;
      end else begin
        overflow_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
      data_q    <= '0;
    end else begin
      pending_q <= pending_d;
      data_q    <= data_d;
    end
  end

  assign pending_o      = pending_q;
  assign pending_next_o = pending_d;
  assign data_o         = data_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: round-robin between register-read bytes and 16-bit ALU
// results, feeding the UART TX one byte at a time (ALU words LSB first) and
// using TX busy as flow control.
// Ports:
//   clk_i, rst_ni                      TX-domain clock, async active-low reset
//   reg_rd_data_i, reg_rd_valid_i      source 0 byte and strobe
//   alu_out_i, alu_out_valid_i         source 1 word and strobe
//   tx_busy_i                          busy from UART TX
//   ovf_clr_i                          clears overflow_o and tx_err_o
//   tx_p_data_o, tx_data_valid_o       byte and one-cycle strobe to UART TX
//   sched_idle_o                       idle with nothing pending
//   overflow_o                         sticky: request dropped
//   tx_err_o                           sticky: busy never rose after a byte
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DATA_WIDTH-1:0]   reg_rd_data_i,
  input  logic                    reg_rd_valid_i,
  input  logic [2*DATA_WIDTH-1:0] alu_out_i,
  input  logic                    alu_out_valid_i,
  input  logic                    tx_busy_i,
  input  logic                    ovf_clr_i,
  output logic [DATA_WIDTH-1:0]   tx_p_data_o,
  output logic                    tx_data_valid_o,
  output logic                    sched_idle_o,
  output logic                    overflow_o,
  output logic                    tx_err_o
);

  localparam int CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  logic                    reg_pend, reg_pend_next, reg_ovf, grant_reg;
  logic                    alu_pend, alu_pend_next, alu_ovf, grant_alu;
  logic [DATA_WIDTH-1:0]   reg_data;
  logic [2*DATA_WIDTH-1:0] alu_data;

  uart_sched_pending #(.WIDTH(DATA_WIDTH)) u_pend_reg (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .valid_i        (reg_rd_valid_i),
    .data_i         (reg_rd_data_i),
    .grant_i        (grant_reg),
    .pending_o      (reg_pend),
    .pending_next_o (reg_pend_next),
    .data_o         (reg_data),
    .overflow_o     (reg_ovf)
  );

  uart_sched_pending #(.WIDTH(2*DATA_WIDTH)) u_pend_alu (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .valid_i        (alu_out_valid_i),
    .data_i         (alu_out_i),
    .grant_i        (grant_alu),
    .pending_o      (alu_pend),
    .pending_next_o (alu_pend_next),
    .data_o         (alu_data),
    .overflow_o     (alu_ovf)
  );

  sched_state_t            state_q, state_d;
  logic                    last_src_q, last_src_d;
  logic [2*DATA_WIDTH-1:0] frame_q, frame_d;
  logic                    idx_q, idx_d;
  logic                    last_idx_q, last_idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   tx_p_data_q, tx_p_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    sched_idle_q, sched_idle_d;
  logic                    ovf_q, ovf_d;
  logic                    err_q, err_d;
  logic                    sel_alu, timeout;

  always_comb begin
    state_d     = state_q;
    last_src_d  = last_src_q;
    frame_d     = frame_q;
    idx_d       = idx_q;
    last_idx_d  = last_idx_q;
    cnt_d       = cnt_q;
    tx_p_data_d = tx_p_data_q;
    tx_valid_d  = 1'b0;
    grant_reg   = 1'b0;
    grant_alu   = 1'b0;
    sel_alu     = 1'b0;
    timeout     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!tx_busy_i && (reg_pend || alu_pend)) begin
          // On a tie, serve the source that was not served last.
          if (reg_pend && alu_pend) sel_alu = (last_src_q == 1'(SRC_REG));
          else                      sel_alu = alu_pend;
          grant_alu   = sel_alu;
          grant_reg   = ~sel_alu;
          last_src_d  = sel_alu ? 1'(SRC_ALU) : 1'(SRC_REG);
          frame_d     = sel_alu ? alu_data : {{DATA_WIDTH{1'b0}}, reg_data};
          last_idx_d  = sel_alu ? 1'(BYTES_ALU - 1) : 1'(BYTES_REG - 1);
          idx_d       = 1'b0;
          tx_valid_d  = 1'b1;
          tx_p_data_d = frame_d[DATA_WIDTH-1:0];
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        cnt_d   = '0;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (tx_busy_i) begin
          state_d = ST_WAIT_LO;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          // TX never acknowledged: drop the rest of the frame.
          timeout = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy_i) begin
          if (idx_q != last_idx_q) begin
            idx_d       = idx_q + 1'b1;
            tx_valid_d  = 1'b1;
            tx_p_data_d = idx_d ? frame_q[2*DATA_WIDTH-1:DATA_WIDTH]
                                : frame_q[DATA_WIDTH-1:0];
            state_d     = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sched_idle_d = (state_d == ST_IDLE) && !reg_pend_next && !alu_pend_next;
    // A setting event beats a simultaneous clear.
    ovf_d = (reg_ovf || alu_ovf) ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);
    err_d = timeout ? 1'b1 : (ovf_clr_i ? 1'b0 : err_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      last_src_q   <= 1'(SRC_ALU);
      frame_q      <= '0;
      idx_q        <= 1'b0;
      last_idx_q   <= 1'b0;
      cnt_q        <= '0;
      tx_p_data_q  <= '0;
      tx_valid_q   <= 1'b0;
      sched_idle_q <= 1'b1;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_src_q   <= last_src_d;
      frame_q      <= frame_d;
      idx_q        <= idx_d;
      last_idx_q   <= last_idx_d;
      cnt_q        <= cnt_d;
      tx_p_data_q  <= tx_p_data_d;
      tx_valid_q   <= tx_valid_d;
      sched_idle_q <= sched_idle_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
    end
  end

  assign tx_p_data_o     = tx_p_data_q;
  assign tx_data_valid_o = tx_valid_q;
  assign sched_idle_o    = sched_idle_q;
  assign overflow_o      = ovf_q;
  assign tx_err_o        = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: table of request vectors (hand-written
// plus random) checked against a transaction-level ordering model, then
// directed sequences for overflow, busy timeout and mid-frame reset.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  reg_rd_data;
  logic        reg_rd_valid;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic        tx_busy;
  logic        ovf_clr;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid, sched_idle, overflow, tx_err;

  always #5 clk = ~clk;

  uart_tx_sched #(.DATA_WIDTH(8), .BUSY_TIMEOUT(4)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .reg_rd_data_i   (reg_rd_data),
    .reg_rd_valid_i  (reg_rd_valid),
    .alu_out_i       (alu_out),
    .alu_out_valid_i (alu_out_valid),
    .tx_busy_i       (tx_busy),
    .ovf_clr_i       (ovf_clr),
    .tx_p_data_o     (tx_p_data),
    .tx_data_valid_o (tx_data_valid),
    .sched_idle_o    (sched_idle),
    .overflow_o      (overflow),
    .tx_err_o        (tx_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic hold_busy = 1'b0;
  logic model_busy = 1'b0;
  bit never_busy = 1'b0;
  int busy_len = 1;
  int viol = 0;
  logic [7:0] cap[$];
  int cap_cyc[$];

  assign tx_busy = hold_busy | model_busy;

  // UART TX model: busy rises one cycle after a strobe and stays high busy_len cycles.
  initial begin : tx_model
    int left;
    bit start_next;
    left = 0;
    start_next = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (left > 0) begin
        left--;
        if (left == 0) model_busy = 1'b0;
      end
      if (start_next) begin
        model_busy = 1'b1;
        left = busy_len;
        start_next = 0;
      end
      if (tx_data_valid) begin
        cap.push_back(tx_p_data);
        cap_cyc.push_back(cyc);
        if (tx_busy) viol++;
        if (!never_busy) start_next = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    reg_rd_valid = 1'b0;
    alu_out_valid = 1'b0;
    ovf_clr = 1'b0;
    while (!(sched_idle && !tx_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: got busy expected idle", name);
    end
  endtask

  typedef struct packed {
    logic        hand;
    logic        do_reg;
    logic        do_alu;
    logic [7:0]  rd;
    logic [15:0] alu;
    logic [3:0]  blen;
    logic [1:0]  exp_n;
    logic [23:0] exp;
    logic        first_alu;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  // Ordering model: lone request goes out alone; a tie goes to whichever source
  // was not served last; the later frame follows the earlier one.
  function automatic void model(input vec_t v, inout bit last_alu,
                                output logic [1:0] n, output logic [23:0] bytes,
                                output logic first_alu);
    logic [7:0] q[$];
    if (v.do_reg && v.do_alu) first_alu = !last_alu;
    else                      first_alu = v.do_alu;
    if (first_alu) begin
      q.push_back(v.alu[7:0]);
      q.push_back(v.alu[15:8]);
      if (v.do_reg) q.push_back(v.rd);
      last_alu = !v.do_reg;
    end else begin
      q.push_back(v.rd);
      if (v.do_alu) begin
        q.push_back(v.alu[7:0]);
        q.push_back(v.alu[15:8]);
      end
      last_alu = v.do_alu;
    end
    n = 2'(q.size());
    bytes = '0;
    for (int i = 0; i < q.size(); i++) bytes[i*8 +: 8] = q[i];
  endfunction

  function automatic vec_t mk(input bit r, input bit a, input logic [7:0] rd,
                              input logic [15:0] alu, input int blen,
                              input int n, input logic [23:0] exp, input bit fa);
    vec_t v;
    v.hand = 1'b1; v.do_reg = r; v.do_alu = a; v.rd = rd; v.alu = alu;
    v.blen = 4'(blen); v.exp_n = 2'(n); v.exp = exp; v.first_alu = fa;
    return v;
  endfunction

  task automatic run_vec(input int i, input vec_t v);
    int c0;
    int brk;
    int g;
    busy_len = int'(v.blen);
    cap.delete();
    cap_cyc.delete();
    viol = 0;
    @(negedge clk);
    reg_rd_data = v.rd;
    reg_rd_valid = v.do_reg;
    alu_out = v.alu;
    alu_out_valid = v.do_alu;
    c0 = cyc;
    wait_idle("vec");
    $display("vec %0d reg=%0b alu=%0b rd=%02h alu=%04h busy=%0d sent=%0d", i, v.do_reg,
             v.do_alu, v.rd, v.alu, v.blen, cap.size());
    chk("vec_count", 32'(cap.size()), 32'(v.exp_n));
    for (int b = 0; b < int'(v.exp_n) && b < cap.size(); b++)
      chk("vec_byte", 32'(cap[b]), 32'(v.exp[b*8 +: 8]));
    if (cap.size() > 0) chk("vec_latency", 32'(cap_cyc[0] - c0), 32'd2);
    brk = (v.exp_n == 2'd3) ? (v.first_alu ? 2 : 1) : 0;
    for (int b = 1; b < int'(v.exp_n) && b < cap.size(); b++) begin
      g = int'(v.blen) + ((b == brk) ? 3 : 2);
      chk("vec_gap", 32'(cap_cyc[b] - cap_cyc[b-1]), 32'(g));
    end
    chk("vec_busy_viol", 32'(viol), 32'd0);
    chk("vec_flags", {30'd0, overflow, tx_err}, 32'd0);
  endtask

  initial begin : main
    bit last_alu;
    logic [1:0] mn;
    logic [23:0] mb;
    logic mf;
    int kind;

    rst_n = 1'b0;
    reg_rd_data = '0; reg_rd_valid = 1'b0;
    alu_out = '0; alu_out_valid = 1'b0;
    ovf_clr = 1'b0;

    vecs[0] = mk(1, 0, 8'hA5, 16'h0000, 10, 1, 24'h0000A5, 0);
    vecs[1] = mk(0, 1, 8'h00, 16'h1234, 3, 2, 24'h001234, 1);
    vecs[2] = mk(1, 1, 8'h3C, 16'hBEEF, 2, 3, 24'hBEEF3C, 0);
    vecs[3] = mk(1, 0, 8'h77, 16'h0000, 1, 1, 24'h000077, 0);
    vecs[4] = mk(1, 1, 8'h99, 16'hCAFE, 2, 3, 24'h99CAFE, 1);
    for (int i = 5; i < NV; i++) begin
      kind = int'($urandom_range(0, 2));
      vecs[i].hand   = 1'b0;
      vecs[i].do_reg = (kind != 1);
      vecs[i].do_alu = (kind != 0);
      vecs[i].rd     = 8'($urandom);
      vecs[i].alu    = 16'($urandom);
      vecs[i].blen   = 4'($urandom_range(1, 5));
    end
    last_alu = 1'b1;
    for (int i = 0; i < NV; i++) begin
      model(vecs[i], last_alu, mn, mb, mf);
      if (!vecs[i].hand) begin
        vecs[i].exp_n = mn;
        vecs[i].exp = mb;
        vecs[i].first_alu = mf;
      end
    end

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(tx_data_valid), 32'd0);
    chk("rst_data", 32'(tx_p_data), 32'd0);
    chk("rst_idle", 32'(sched_idle), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_err", 32'(tx_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Overflow, set-beats-clear, and grant coinciding with a new request.
    busy_len = 2;
    cap.delete(); cap_cyc.delete();
    @(negedge clk); hold_busy = 1'b1;
    @(negedge clk); reg_rd_data = 8'h11; reg_rd_valid = 1'b1;
    @(negedge clk); chk("ovf_before", 32'(overflow), 32'd0); reg_rd_data = 8'h22;
    @(negedge clk); chk("ovf_set", 32'(overflow), 32'd1); reg_rd_data = 8'h33; ovf_clr = 1'b1;
    @(negedge clk); chk("ovf_set_wins", 32'(overflow), 32'd1); reg_rd_valid = 1'b0;
    @(negedge clk); chk("ovf_clr", 32'(overflow), 32'd0); ovf_clr = 1'b0;
    chk("ovf_held_no_tx", 32'(cap.size()), 32'd0);
    hold_busy = 1'b0; reg_rd_data = 8'h55; reg_rd_valid = 1'b1;
    wait_idle("ovf");
    $display("ovf seq sent=%0d", cap.size());
    chk("ovf_count", 32'(cap.size()), 32'd2);
    if (cap.size() >= 2) begin
      chk("ovf_byte0", 32'(cap[0]), 32'h11);
      chk("ovf_byte1", 32'(cap[1]), 32'h55);
    end
    chk("ovf_grant_same_cycle", 32'(overflow), 32'd0);

    // Busy never rises: abandon after the 4th WAIT_HI cycle.
    never_busy = 1'b1;
    cap.delete(); cap_cyc.delete();
    @(negedge clk); alu_out = 16'hABCD; alu_out_valid = 1'b1;
    @(negedge clk); alu_out_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("err_not_yet", 32'(tx_err), 32'd0);
    @(negedge clk);
    chk("err_set", 32'(tx_err), 32'd1);
    chk("err_idle", 32'(sched_idle), 32'd1);
    repeat (10) @(negedge clk);
    $display("timeout seq sent=%0d err=%0b", cap.size(), tx_err);
    chk("err_count", 32'(cap.size()), 32'd1);
    if (cap.size() > 0) chk("err_byte0", 32'(cap[0]), 32'hCD);
    ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("err_clr", 32'(tx_err), 32'd0);
    never_busy = 1'b0;

    // Asynchronous reset in WAIT_LO of an ALU frame.
    busy_len = 8;
    cap.delete(); cap_cyc.delete();
    @(negedge clk); alu_out = 16'h1234; alu_out_valid = 1'b1;
    @(negedge clk); alu_out_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_data", 32'(tx_p_data), 32'h34);
    chk("pre_rst_idle", 32'(sched_idle), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", 32'(tx_p_data), 32'd0);
    chk("arst_idle", 32'(sched_idle), 32'd1);
    chk("arst_valid", 32'(tx_data_valid), 32'd0);
    chk("arst_flags", {30'd0, overflow, tx_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cap.delete(); cap_cyc.delete();
    repeat (20) @(negedge clk);
    $display("reset seq sent_after=%0d", cap.size());
    chk("post_rst_no_tx", 32'(cap.size()), 32'd0);
    chk("post_rst_idle", 32'(sched_idle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
